// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - seq_core shared opcodes, field positions and state type
//
// Purpose: constants shared by the sequencer decode and core.
// Optional feature macro: SEQ_ERROR_EN (the ERROR state is only used when defined).
package seq_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NO = 4'h0;
  localparam opcode_t OP_CI = 4'h1;
  localparam opcode_t OP_CR = 4'h2;
  localparam opcode_t OP_JI = 4'h3;
  localparam opcode_t OP_JR = 4'h4;
  localparam opcode_t OP_JZ = 4'h5;
  localparam opcode_t OP_JN = 4'h6;

  // Instruction field bit positions
  localparam int OP_MSB   = 19;
  localparam int OP_LSB   = 16;
  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 8;
  localparam int DST_MSB  = 14;
  localparam int DST_LSB  = 12;
  localparam int CMD_MSB  = 11;
  localparam int CMD_LSB  = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;
  localparam int SEL_MSB  = 1;
  localparam int SEL_LSB  = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

  // Sequential fetch address; wraps 0xFF -> 0x00 by width.
  function automatic logic [7:0] pc_inc(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/seq_if.sv
// rtl/seq_if.sv - seq_core instruction / register bus interface
//
// Purpose: bundles the instruction input, input registers and output register
// bus of the sequencer.
// Signals: inst[19:0], inst_en, ireg_0..ireg_3[7:0] (to core);
//          next[7:0], oreg[11:0], oreg_wen[7:0], error (SEQ_ERROR_EN only) (from core).
// Modports: master (instruction source / register file side), slave (seq_core).
interface seq_if;

  logic [19:0] inst;
  logic        inst_en;
  logic [7:0]  ireg_0;
  logic [7:0]  ireg_1;
  logic [7:0]  ireg_2;
  logic [7:0]  ireg_3;
  logic [7:0]  next;
  logic [11:0] oreg;
  logic [7:0]  oreg_wen;
`ifdef SEQ_ERROR_EN
  logic        error;

  modport master (output inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
                  input  next, oreg, oreg_wen, error);
  modport slave  (input  inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
                  output next, oreg, oreg_wen, error);
`else
  modport master (output inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
                  input  next, oreg, oreg_wen);
  modport slave  (input  inst, inst_en, ireg_0, ireg_1, ireg_2, ireg_3,
                  output next, oreg, oreg_wen);
`endif

endinterface

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - seq_core combinational instruction decode
//
// Purpose: splits the instruction into fields, selects the addressed input
// register and flags whether the opcode is defined.
// Ports: inst_i[19:0], ireg_0_i..ireg_3_i[7:0] in;
//        op_o, dst_o, cmd_o, imm_o, addr_o, ireg_sel_o, op_valid_o out.
module seq_decode
  import seq_pkg::*;
(
  input  logic [19:0] inst_i,
  input  logic [7:0]  ireg_0_i,
  input  logic [7:0]  ireg_1_i,
  input  logic [7:0]  ireg_2_i,
  input  logic [7:0]  ireg_3_i,
  output opcode_t     op_o,
  output logic [2:0]  dst_o,
  output logic [3:0]  cmd_o,
  output logic [7:0]  imm_o,
  output logic [7:0]  addr_o,
  output logic [7:0]  ireg_sel_o,
  output logic        op_valid_o
);

  logic [1:0] sel;

  assign op_o   = inst_i[OP_MSB:OP_LSB];
  assign dst_o  = inst_i[DST_MSB:DST_LSB];
  assign cmd_o  = inst_i[CMD_MSB:CMD_LSB];
  assign imm_o  = inst_i[IMM_MSB:IMM_LSB];
  assign addr_o = inst_i[ADDR_MSB:ADDR_LSB];
  assign sel    = inst_i[SEL_MSB:SEL_LSB];

  always_comb begin
    ireg_sel_o = ireg_0_i;
    case (sel)
      2'd0:    ireg_sel_o = ireg_0_i;
      2'd1:    ireg_sel_o = ireg_1_i;
      2'd2:    ireg_sel_o = ireg_2_i;
      default: ireg_sel_o = ireg_3_i;
    endcase
  end

  // Opcodes are dense from 0, so anything above JN is undefined.
  assign op_valid_o = (op_o <= OP_JN);

endmodule

// File: rtl/seq_core.sv
// rtl/seq_core.sv - microcoded controller program sequencer
//
// Purpose: executes one 20-bit instruction per clock, updating the program
// counter (next) and writing output registers through oreg/oreg_wen.
// Ports: clock, reset (synchronous, active-low), bus (seq_if.slave).
// Optional feature macro: SEQ_ERROR_EN - adds the ERROR state and bus.error;
// when undefined, invalid opcodes behave as NO.
module seq_core
  import seq_pkg::*;
(
  input  logic clock,
  input  logic reset,
  seq_if.slave bus
);

  opcode_t    op;
  logic [2:0] dst;
  logic [3:0] cmd;
  logic [7:0] imm;
  logic [7:0] addr;
  logic [7:0] ireg_sel;
  logic       op_valid;

  seq_decode u_decode (
    .inst_i     (bus.inst),
    .ireg_0_i   (bus.ireg_0),
    .ireg_1_i   (bus.ireg_1),
    .ireg_2_i   (bus.ireg_2),
    .ireg_3_i   (bus.ireg_3),
    .op_o       (op),
    .dst_o      (dst),
    .cmd_o      (cmd),
    .imm_o      (imm),
    .addr_o     (addr),
    .ireg_sel_o (ireg_sel),
    .op_valid_o (op_valid)
  );

  logic [7:0]  next_q, next_d;
  logic [11:0] oreg_q, oreg_d;
  logic [7:0]  wen_q, wen_d;
  logic [7:0]  next_inc;
  logic        active;

`ifdef SEQ_ERROR_EN
  state_e state_q, state_d;
  assign active = bus.inst_en && (state_q == ST_RUN);
`else
  assign active = bus.inst_en;
`endif

  assign next_inc = pc_inc(next_q);

  always_comb begin
    next_d = next_q;
    oreg_d = oreg_q;
    wen_d  = '0;
`ifdef SEQ_ERROR_EN
    state_d = state_q;
`endif
    if (active) begin
      if (!op_valid) begin
`ifdef SEQ_ERROR_EN
        state_d = ST_ERROR;
`else
        next_d = next_inc;
`endif
      end else begin
        case (op)
          OP_CI: begin
            oreg_d = {cmd, imm};
            wen_d  = 8'd1 << dst;
            next_d = next_inc;
          end
          OP_CR: begin
            oreg_d = {cmd, ireg_sel};
            wen_d  = 8'd1 << dst;
            next_d = next_inc;
          end
          OP_JI:   next_d = addr;
          OP_JR:   next_d = ireg_sel;
          OP_JZ:   next_d = (ireg_sel == 8'd0) ? addr : next_inc;
          OP_JN:   next_d = (ireg_sel != 8'd0) ? addr : next_inc;
          default: next_d = next_inc;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      next_q  <= '0;
      oreg_q  <= '0;
      wen_q   <= '0;
`ifdef SEQ_ERROR_EN
      state_q <= ST_RUN;
`endif
    end else begin
      next_q  <= next_d;
      oreg_q  <= oreg_d;
      wen_q   <= wen_d;
`ifdef SEQ_ERROR_EN
      state_q <= state_d;
`endif
    end
  end

  assign bus.next     = next_q;
  assign bus.oreg     = oreg_q;
  assign bus.oreg_wen = wen_q;
`ifdef SEQ_ERROR_EN
  assign bus.error    = (state_q == ST_ERROR);
`endif

endmodule

// File: tb/tb_seq_core.sv
// tb/tb_seq_core.sv - self-checking bench for seq_core
module tb_seq_core;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] ireg [4];

  int         m_next;
  int         m_oreg;
  int         m_wen;
  bit         m_err;

  always #5 clk = ~clk;

  seq_if bus ();

  assign bus.ireg_0 = ireg[0];
  assign bus.ireg_1 = ireg[1];
  assign bus.ireg_2 = ireg[2];
  assign bus.ireg_3 = ireg[3];

  seq_core u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] mk_ci(input int dst, input int cmd, input int imm);
    logic [19:0] w;
    w = 20'h10000;
    w[14:12] = dst[2:0];
    w[11:8]  = cmd[3:0];
    w[7:0]   = imm[7:0];
    return w;
  endfunction

  function automatic logic [19:0] mk_cr(input int dst, input int cmd, input int sel);
    logic [19:0] w;
    w = 20'h20000;
    w[14:12] = dst[2:0];
    w[11:8]  = cmd[3:0];
    w[1:0]   = sel[1:0];
    return w;
  endfunction

  function automatic logic [19:0] mk_j(input int op, input int addr, input int sel);
    logic [19:0] w;
    w = '0;
    w[19:16] = op[3:0];
    w[15:8]  = addr[7:0];
    w[1:0]   = sel[1:0];
    return w;
  endfunction

  // Reference: what the sequencer must do with one instruction.
  task automatic model_exec(input logic [19:0] ins, input logic en);
    int op;
    int sel_val;
    int inc;
    op      = int'(ins[19:16]);
    sel_val = int'(ireg[ins[1:0]]);
    inc     = (m_next + 1) % 256;
    m_wen   = 0;
    if (!en || m_err) return;
    case (op)
      0: m_next = inc;
      1: begin m_oreg = int'(ins[11:8]) * 256 + int'(ins[7:0]); m_wen = 1 << ins[14:12]; m_next = inc; end
      2: begin m_oreg = int'(ins[11:8]) * 256 + sel_val;        m_wen = 1 << ins[14:12]; m_next = inc; end
      3: m_next = int'(ins[15:8]);
      4: m_next = sel_val;
      5: m_next = (sel_val == 0) ? int'(ins[15:8]) : inc;
      6: m_next = (sel_val != 0) ? int'(ins[15:8]) : inc;
      default: begin
`ifdef SEQ_ERROR_EN
        m_err = 1'b1;
`else
        m_next = inc;
`endif
      end
    endcase
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".next"}, {24'd0, bus.next}, m_next);
    check({tag, ".oreg"}, {20'd0, bus.oreg}, m_oreg);
    check({tag, ".wen"},  {24'd0, bus.oreg_wen}, m_wen);
`ifdef SEQ_ERROR_EN
    check({tag, ".error"}, {31'd0, bus.error}, {31'd0, m_err});
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    m_next = 0; m_oreg = 0; m_wen = 0; m_err = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [19:0] ins, input logic en);
    bus.inst    = ins;
    bus.inst_en = en;
    @(posedge clk);
    model_exec(ins, en);
    #1;
  endtask

  initial begin
    logic [19:0] w;
    rst_n = 1'b1;
    bus.inst = '0;
    bus.inst_en = 1'b0;
    for (int i = 0; i < 4; i++) ireg[i] = 8'h00;
    m_next = 0; m_oreg = 0; m_wen = 0; m_err = 1'b0;

    // Dirty the outputs before reset so the reset check is meaningful
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    compare_all("reset");
    check("reset.next_c", {24'd0, bus.next}, 32'h00);

    step(mk_ci(2, 1, 8'hAA), 1'b1);
    compare_all("ci");
    check("ci.oreg_c", {20'd0, bus.oreg}, 32'h1AA);
    check("ci.wen_c", {24'd0, bus.oreg_wen}, 32'h04);
    ireg[2] = 8'hEE;
    step(mk_cr(3, 2, 2), 1'b1);
    compare_all("cr");
    check("cr.oreg_c", {20'd0, bus.oreg}, 32'h2EE);
    check("cr.wen_c", {24'd0, bus.oreg_wen}, 32'h08);
    check("cr.next_c", {24'd0, bus.next}, 32'h02);
    step(20'h0, 1'b0);
    check("idle.wen_c", {24'd0, bus.oreg_wen}, 32'h00);

    step(mk_j(3, 8'h1A, 0), 1'b1);
    check("ji.next_c", {24'd0, bus.next}, 32'h1A);
    ireg[1] = 8'h7B;
    step(mk_j(4, 0, 1), 1'b1);
    check("jr.next_c", {24'd0, bus.next}, 32'h7B);
    ireg[3] = 8'h00;
    step(mk_j(5, 8'h2A, 3), 1'b1);
    check("jz_taken.next_c", {24'd0, bus.next}, 32'h2A);
    ireg[0] = 8'h11;
    step(mk_j(5, 8'h4A, 0), 1'b1);
    check("jz_fall.next_c", {24'd0, bus.next}, 32'h2B);
    ireg[1] = 8'h22;
    step(mk_j(6, 8'hB0, 1), 1'b1);
    check("jn_taken.next_c", {24'd0, bus.next}, 32'hB0);
    ireg[2] = 8'h00;
    step(mk_j(6, 8'h8A, 2), 1'b1);
    check("jn_fall.next_c", {24'd0, bus.next}, 32'hB1);
    step(mk_j(0, 0, 0), 1'b1);
    check("no.next_c", {24'd0, bus.next}, 32'hB2);
    compare_all("jumps");

    step(mk_ci(5, 4, 8'h33), 1'b0);
    check("disabled.next_c", {24'd0, bus.next}, 32'hB2);
    check("disabled.wen_c", {24'd0, bus.oreg_wen}, 32'h00);
    check("disabled.oreg_c", {20'd0, bus.oreg}, 32'h2EE);
    ireg[2] = 8'h07;
    step(mk_j(4, 0, 2), 1'b1);
    check("jr2.next_c", {24'd0, bus.next}, 32'h07);

    step(20'hF0000, 1'b1);
    ireg[3] = 8'h00;
`ifdef SEQ_ERROR_EN
    check("bad_op.next_c", {24'd0, bus.next}, 32'h07);
    check("bad_op.error_c", {31'd0, bus.error}, 32'h1);
    step(mk_j(5, 8'hEF, 3), 1'b1);
    check("err_ignore.next_c", {24'd0, bus.next}, 32'h07);
`else
    check("bad_op.next_c", {24'd0, bus.next}, 32'h08);
    step(mk_j(5, 8'hEF, 3), 1'b1);
    check("after_bad.next_c", {24'd0, bus.next}, 32'hEF);
`endif
    compare_all("bad_op");

    do_reset();
    compare_all("reset2");
`ifdef SEQ_ERROR_EN
    check("reset2.error_c", {31'd0, bus.error}, 32'h0);
`endif
    step(mk_j(3, 8'h48, 0), 1'b1);
    check("ji48.next_c", {24'd0, bus.next}, 32'h48);
    step(mk_j(0, 0, 0), 1'b1);
    check("no49.next_c", {24'd0, bus.next}, 32'h49);
    step(mk_j(3, 8'hFF, 0), 1'b1);
    step(mk_j(0, 0, 0), 1'b1);
    check("wrap.next_c", {24'd0, bus.next}, 32'h00);
    compare_all("wrap");

    // Randomized run against the reference model
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++)
        ireg[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        w = 20'($urandom);
        if ($urandom_range(0, 15) != 0) w[19:16] = 4'($urandom_range(0, 6));
        step(w, ($urandom_range(0, 4) != 0));
      end
      compare_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
